clz_denormalize: RTL and testbench

Multi-cycle denormalizer, the decode-side counterpart of `count_lead_zero`. It takes a normalized word and a leading-zero count and restores the original alignment by shifting the word right by that count. Alongside the result it produces a sticky bit: the OR of every bit shifted out. It sits on the unpack/decode path after a normalize stage and uses valid/ready handshakes on both sides.

---
 rtl/clz_denormalize.sv | 135 +++++++++++++
 tb/tb_clz_denormalize.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/clz_denormalize.sv
// clz_denormalize
//
// Multi-cycle denormalizer. It accepts a normalized word and a leading-zero
// count, and shifts the word right by that count. The shift takes one binary
// stage per cycle, from weight 2^(W_OUT-1) down to 2^0. A sticky bit collects
// the OR of every bit shifted out. There is no bypass path: a result has to be
// consumed, and the block has to return to idle, before it accepts the next
// word.
//
// Parameters
//   W_IN   data width; must be a power of two and >= 2
//   W_OUT  count width; leave at the default $clog2(W_IN)
//
// Ports
//   clk         rising-edge clock
//   rst         synchronous, active-high reset
//   in_data     normalized word
//   in_count    right-shift amount, 0..W_IN-1
//   in_valid    input word present
//   in_ready    block can accept an input (idle and not in reset)
//   out_data    in_data >> in_count, zero-filled from the MSB
//   out_sticky  OR of all bits shifted out
//   out_valid   result present; data and sticky are held until accepted
//   out_ready   downstream accepts the result

module clz_denormalize #(
  parameter int unsigned W_IN  = 8,
  parameter int unsigned W_OUT = $clog2(W_IN)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [W_IN-1:0]  in_data,
  input  logic [W_OUT-1:0] in_count,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [W_IN-1:0]  out_data,
  output logic             out_sticky,
  output logic             out_valid,
  input  logic             out_ready
);

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StDone
  } state_e;

  state_e           state_q, state_d;
  logic [W_IN-1:0]  work_q, work_d;
  logic [W_OUT-1:0] cnt_q, cnt_d;
  logic [W_OUT-1:0] stage_q, stage_d;
  logic             sticky_q, sticky_d;

  // Result of the stage selected by stage_q.
  logic [W_IN-1:0]  stage_shifted;
  logic             stage_dropped;

  assign in_ready   = (state_q == StIdle) && !rst;
  assign out_valid  = (state_q == StDone);
  assign out_data   = work_q;
  assign out_sticky = sticky_q;

  // Stage k shifts by 2^k when count bit k is set. The bits that are lost are
  // the low 2^k bits of the working word. Shifting the word left by
  // W_IN - 2^k keeps exactly those bits, so an OR-reduce gives their sticky
  // contribution.
  always_comb begin
    stage_shifted = work_q;
    stage_dropped = 1'b0;
    for (int unsigned k = 0; k < W_OUT; k++) begin
      if ((stage_q == W_OUT'(k)) && cnt_q[k]) begin
        stage_shifted = work_q >> (2 ** k);
        stage_dropped = |(work_q << (W_IN - (2 ** k)));
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    work_d   = work_q;
    cnt_d    = cnt_q;
    stage_d  = stage_q;
    sticky_d = sticky_q;

    unique case (state_q)
      StIdle: begin
        if (in_valid && in_ready) begin
          state_d  = StShift;
          work_d   = in_data;
          cnt_d    = in_count;
          sticky_d = 1'b0;
          stage_d  = W_OUT'(W_OUT - 1);
        end
      end

      StShift: begin
        work_d   = stage_shifted;
        sticky_d = sticky_q | stage_dropped;
        if (stage_q == '0) begin
          state_d = StDone;
        end else begin
          stage_d = stage_q - W_OUT'(1);
        end
      end

      StDone: begin
        // out_ready is ignored in every other state.
        if (out_ready) begin
          state_d = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      work_q   <= '0;
      cnt_q    <= '0;
      stage_q  <= '0;
      sticky_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      work_q   <= work_d;
      cnt_q    <= cnt_d;
      stage_q  <= stage_d;
      sticky_q <= sticky_d;
    end
  end

endmodule

// File: tb/tb_clz_denormalize.sv
// Self-checking bench for clz_denormalize (W_IN = 8).
//
// The stimulus side pushes an expected result for every accepted word into a
// scoreboard queue. A monitor pops that queue on every output handshake and
// compares the result. It also checks the latency from acceptance to the
// rising edge of out_valid, and that the outputs stay stable under
// backpressure.

module tb_clz_denormalize;

  localparam int unsigned W  = 8;
  localparam int unsigned WO = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  in_data;
  logic [WO-1:0] in_count;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  out_data;
  logic          out_sticky;
  logic          out_valid;
  logic          out_ready;

  clz_denormalize #(
    .W_IN (W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_count   (in_count),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_data   (out_data),
    .out_sticky (out_sticky),
    .out_valid  (out_valid),
    .out_ready  (out_ready)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;
  bit rand_rdy = 1'b0;

  typedef struct {
    logic [W-1:0] data;
    logic         sticky;
    int           acc;
  } exp_t;

  exp_t sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference model: an integer divide gives the shifted value, and the
  // remainder holds exactly the bits that were dropped.
  function automatic exp_t model(input logic [W-1:0] d, input int c, input int acc);
    exp_t e;
    int   div;
    int   v;
    div      = 1 << c;
    v        = int'(d);
    e.data   = W'(v / div);
    e.sticky = (v % div) != 0;
    e.acc    = acc;
    return e;
  endfunction

  // Monitor: samples on the falling edge; inputs change just after the rising edge.
  logic         mon_held   = 1'b0;
  logic         mon_prev_v = 1'b0;
  logic [W-1:0] mon_prev_d = '0;
  logic         mon_prev_s = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      mon_held   = 1'b0;
      mon_prev_v = 1'b0;
    end else begin
      if (out_valid && !mon_prev_v) begin
        check("valid_has_expectation", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) check("latency", 32'(cyc - sb[0].acc), 32'(WO + 1));
      end
      if (out_valid && mon_held) begin
        check("stall_data_stable", 32'(out_data), 32'(mon_prev_d));
        check("stall_sticky_stable", 32'(out_sticky), 32'(mon_prev_s));
      end
      if (out_valid && out_ready) begin
        check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          exp_t e;
          e = sb.pop_front();
          check("out_data", 32'(out_data), 32'(e.data));
          check("out_sticky", 32'(out_sticky), 32'(e.sticky));
        end
      end
      mon_held   = out_valid && !out_ready;
      mon_prev_v = out_valid;
      mon_prev_d = out_data;
      mon_prev_s = out_sticky;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
  endtask

  // Called just after a rising edge. Holds in_valid until the word is accepted.
  task automatic send(input logic [W-1:0] d, input logic [WO-1:0] c, input bit push);
    int guard;
    bit ok;
    guard    = 0;
    ok       = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    in_count = c;
    while (guard < 200) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
      guard++;
      step();
    end
    if (!ok) check("accept_timeout", 32'(in_ready), 32'd1);
    else if (push) sb.push_back(model(d, int'(c), cyc));
    step();
    in_valid = 1'b0;
    in_data  = W'($urandom);
    in_count = WO'($urandom);
  endtask

  task automatic wait_valid();
    int g;
    g = 0;
    do begin
      @(negedge clk);
      g++;
    end while (!out_valid && g < 50);
    if (!out_valid) check("wait_valid_timeout", 32'(out_valid), 32'd1);
  endtask

  task automatic wait_idle();
    int g;
    g = 0;
    do begin
      @(negedge clk);
      g++;
    end while (!(sb.size() == 0 && in_ready) && g < 100);
    check("idle_reached", 32'(sb.size() == 0 && in_ready), 32'd1);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_count  = '0;
    out_ready = 1'b0;

    // Reset state.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_sticky", 32'(out_sticky), 32'd0);
    step();
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", 32'(in_ready), 32'd1);

    // 0xB5 >> 3 = 0x16, sticky 1; in_ready returns in cycle 5.
    step();
    out_ready = 1'b1;
    send(8'hB5, 3'd3, 1'b1);
    wait_valid();
    @(negedge clk);
    check("t1_in_ready_c5", 32'(in_ready), 32'd1);
    check("t1_out_valid_c5", 32'(out_valid), 32'd0);

    // Zero count, then maximum count with and without dropped ones.
    step();
    send(8'h80, 3'd0, 1'b1);
    send(8'h80, 3'd7, 1'b1);
    send(8'hFF, 3'd7, 1'b1);
    send(8'h00, 3'd5, 1'b1);
    wait_idle();

    // Backpressure: five stalled cycles with a rejected in_valid during them.
    step();
    out_ready = 1'b0;
    send(8'hC0, 3'd2, 1'b1);
    wait_valid();
    for (int i = 0; i < 5; i++) begin
      step();
      in_valid = 1'b1;
      in_data  = 8'hAA;
      in_count = 3'd1;
      @(negedge clk);
      check("stall_out_data", 32'(out_data), 32'h30);
      check("stall_out_sticky", 32'(out_sticky), 32'd0);
      check("stall_in_ready", 32'(in_ready), 32'd0);
      check("stall_out_valid", 32'(out_valid), 32'd1);
    end
    step();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    step();
    @(negedge clk);
    check("release_out_valid", 32'(out_valid), 32'd0);
    check("release_in_ready", 32'(in_ready), 32'd1);

    // Reset during the second SHIFT cycle; that word must never come out.
    step();
    send(8'h55, 3'd5, 1'b0);
    @(negedge clk);
    step();
    rst = 1'b1;
    @(negedge clk);
    check("midrst_in_ready_low", 32'(in_ready), 32'd0);
    step();
    rst = 1'b0;
    @(negedge clk);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_out_data", 32'(out_data), 32'd0);
    check("midrst_out_sticky", 32'(out_sticky), 32'd0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("midrst_no_valid", 32'(out_valid), 32'd0);
    end
    step();
    send(8'h40, 3'd1, 1'b1);
    wait_idle();

    // Randomized back-to-back run with random backpressure.
    step();
    rand_rdy = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      logic [W-1:0] d;
      d = W'($urandom);
      if ($urandom_range(0, 7) == 0) d = '0;
      send(d, WO'($urandom_range(0, 7)), 1'b1);
    end
    for (int g = 0; g < 200 && sb.size() != 0; g++) step();
    rand_rdy  = 1'b0;
    out_ready = 1'b1;
    repeat (3) step();
    check("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
